// File: rtl/hsi_s_cmd_sched.sv
// hsi_s_cmd_sched: HSI slave-side command sequencer.
// Collects framed commands (SYNC, opcode, ARG_BYTES args, XOR checksum) from the
// rx byte stream and issues them to the SD-side executor. It reports busy and
// sticky status back to the HSI tx path.
// Optional drop statistics: define HSI_S_CMD_SCHED_STAT_EN to add drop_cnt.
module hsi_s_cmd_sched #(
  parameter int          ARG_BYTES = 2,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1023
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [7:0]             q,
  input  logic                   q_rdy,
  input  logic                   cmd_ack,
  input  logic                   cmd_done,
  input  logic                   cmd_err,
  output logic [7:0]             cmd_op,
  output logic [8*ARG_BYTES-1:0] cmd_arg,
  output logic                   cmd_vld,
  output logic                   sd_busy,
  output logic                   sr
`ifdef HSI_S_CMD_SCHED_STAT_EN
  ,output logic [7:0]            drop_cnt
`endif
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int IW = (ARG_BYTES > 1) ? $clog2(ARG_BYTES) : 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(ARG_BYTES - 1);

  typedef enum logic [2:0] {IDLE, OPC, ARG, CHK, ISSUE, EXEC} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            tcnt;
  logic [IW-1:0]            idx;
  logic [7:0]               chk;
  logic [7:0]               op_sh;
  logic [8*ARG_BYTES-1:0]   arg_sh;
  logic                     timed, tmo_hit;
  logic                     tmo, chk_ok, chk_fail, busy_drop, fin;

  assign timed   = (state == OPC) || (state == ARG) || (state == CHK);
  assign tmo_hit = (tcnt == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and single-cycle event flags
  always_comb begin
    state_nxt = state;
    tmo       = 1'b0;
    chk_ok    = 1'b0;
    chk_fail  = 1'b0;
    busy_drop = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (q_rdy && (q == SYNC_BYTE)) state_nxt = OPC;
      OPC: begin
        if (q_rdy)        state_nxt = ARG;
        else if (tmo_hit) begin tmo = 1'b1; state_nxt = IDLE; end
      end
      ARG: begin
        if (q_rdy) begin
          if (idx == IDX_LAST) state_nxt = CHK;
        end else if (tmo_hit) begin
          tmo = 1'b1; state_nxt = IDLE;
        end
      end
      CHK: begin
        if (q_rdy) begin
          if (q == chk) begin chk_ok   = 1'b1; state_nxt = ISSUE; end
          else          begin chk_fail = 1'b1; state_nxt = IDLE;  end
        end else if (tmo_hit) begin
          tmo = 1'b1; state_nxt = IDLE;
        end
      end
      ISSUE: begin
        busy_drop = q_rdy;
        if (cmd_ack) begin
          if (cmd_done) begin fin = 1'b1; state_nxt = IDLE; end
          else          state_nxt = EXEC;
        end
      end
      EXEC: begin
        busy_drop = q_rdy;
        if (cmd_done) begin fin = 1'b1; state_nxt = IDLE; end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame assembly control: inter-byte timer, checksum accumulator, arg index
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tcnt <= '0;
      chk  <= '0;
      idx  <= '0;
    end else begin
      tcnt <= (timed && !q_rdy && !tmo) ? CW'(tcnt + 1'b1) : '0;
      if (q_rdy && state == OPC) begin
        chk <= q;
        idx <= '0;
      end else if (q_rdy && state == ARG) begin
        chk <= chk ^ q;
        idx <= IW'(idx + 1'b1);
      end
    end
  end

  // Shadow opcode/argument capture; first argument byte lands in the MSBs
  always_ff @(posedge clk) begin
    if (q_rdy && state == OPC) op_sh <= q;
    if (q_rdy && state == ARG) begin
      for (int i = 0; i < ARG_BYTES; i++)
        if (idx == IW'(i)) arg_sh[(ARG_BYTES-1-i)*8 +: 8] <= q;
    end
  end

  // Command outputs, handshake and status towards the tx path
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cmd_op  <= '0;
      cmd_arg <= '0;
      cmd_vld <= 1'b0;
      sd_busy <= 1'b0;
      sr      <= 1'b0;
    end else begin
      if (chk_ok) begin
        cmd_op  <= op_sh;
        cmd_arg <= arg_sh;
        cmd_vld <= 1'b1;
        sd_busy <= 1'b1;
        sr      <= 1'b0;
      end else if (chk_fail || tmo) begin
        sr <= 1'b1;
      end
      if (state == ISSUE && cmd_ack) cmd_vld <= 1'b0;
      if (fin) begin
        sd_busy <= 1'b0;
        sr      <= cmd_err;
      end
    end
  end

`ifdef HSI_S_CMD_SCHED_STAT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Drop statistics: one count per cycle carrying any drop event
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                            drop_cnt <= '0;
    else if (busy_drop || chk_fail || tmo) drop_cnt <= sat_inc8(drop_cnt);
  end
`endif

endmodule
